// File: rtl/branch_pkg.sv
// Shared branch-condition encodings and the comparator used by the branch unit.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Widest operand supported by branch_cond.
  localparam int unsigned MAX_XLEN = 64;

  // Operands must be left-justified to MAX_XLEN so the operand MSB sits at bit 63;
  // this keeps signed, unsigned and equality ordering intact for any XLEN <= 64.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic [MAX_XLEN-1:0] a,
                                       input logic [MAX_XLEN-1:0] b);
    logic eq;
    logic lt_s;
    logic lt_u;
    logic res;
    eq   = (a == b);
    lt_u = (a < b);
    lt_s = ($signed(a) < $signed(b));
    case (funct3)
      F3_BEQ:  res = eq;
      F3_BNE:  res = !eq;
      F3_BLT:  res = lt_s;
      F3_BGE:  res = !lt_s;
      F3_BLTU: res = lt_u;
      F3_BGEU: res = !lt_u;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating up/down counters: one combinational read port, one synchronous
// increment/decrement port, synchronous reset to the weakly-not-taken value.
module sat_counter_table #(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CNT_BITS = 2,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic                upd_en,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic                upd_inc
);

  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] upd_cur;
  logic [CNT_BITS-1:0] upd_nxt;

  assign rd_cnt  = cnt_q[rd_idx];
  assign upd_cur = cnt_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_inc) begin
      if (upd_cur != CNT_MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= CNT_RST;
    end else if (upd_en) begin
      cnt_q[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: rtl/branch_unit_bht.sv
// RV64I conditional-branch resolver with a PC-indexed saturating-counter predictor
// and branch / misprediction performance counters.
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned PERF_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_rs2,
  input  logic                 ex_pred_taken,
  output logic                 taken,
  output logic                 mispredict,
  output logic                 illegal_cond,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic [CNT_BITS-1:0] rd_cnt;
  logic                resolve;
  logic                legal;
  logic                cond;
  logic [MAX_XLEN-1:0] op_a;
  logic [MAX_XLEN-1:0] op_b;
  logic [PERF_BITS-1:0] perf_branches_q;
  logic [PERF_BITS-1:0] perf_mispredicts_q;
  logic                unused_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Upper PC bits and the low counter bits only matter to other stages.
  assign unused_bits = ^{if_pc, ex_pc, rd_cnt};

  assign op_a = MAX_XLEN'(ex_rs1) << (MAX_XLEN - XLEN);
  assign op_b = MAX_XLEN'(ex_rs2) << (MAX_XLEN - XLEN);
  assign cond = branch_cond(ex_funct3, op_a, op_b);

  assign resolve      = ex_valid & ex_branch;
  assign illegal_cond = resolve & (ex_funct3[2:1] == 2'b01);
  assign legal        = resolve & ~illegal_cond;
  assign taken        = legal & cond;
  assign mispredict   = legal & (taken != ex_pred_taken);

  sat_counter_table #(
    .ENTRIES  (BHT_ENTRIES),
    .CNT_BITS (CNT_BITS)
  ) u_bht (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (if_idx),
    .rd_cnt  (rd_cnt),
    .upd_en  (legal),
    .upd_idx (ex_idx),
    .upd_inc (taken)
  );

  assign pred_taken = rd_cnt[CNT_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      if (legal)      perf_branches_q    <= perf_branches_q + 1'b1;
      if (mispredict) perf_mispredicts_q <= perf_mispredicts_q + 1'b1;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Scoreboard bench for branch_unit_bht: stimulus queues expected values, the monitor
// compares them against DUT outputs on the falling edge of each cycle.
module tb_branch_unit_bht;
  import branch_pkg::*;

  localparam int K_PRED  = 0;
  localparam int K_TAKEN = 1;
  localparam int K_MISP  = 2;
  localparam int K_ILL   = 3;
  localparam int K_PB    = 4;
  localparam int K_PM    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic [63:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_rs1;
  logic [63:0] ex_rs2;
  logic        ex_pred_taken;
  logic        taken;
  logic        mispredict;
  logic        illegal_cond;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  string       q_name[$];
  int          q_kind[$];
  logic [31:0] q_val[$];
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  branch_unit_bht dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_funct3        (ex_funct3),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pred_taken    (ex_pred_taken),
    .taken            (taken),
    .mispredict       (mispredict),
    .illegal_cond     (illegal_cond),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int kind, input logic [31:0] val);
    q_name.push_back(name);
    q_kind.push_back(kind);
    q_val.push_back(val);
  endtask

  task automatic branch(input logic [63:0] pc, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic pt);
    ex_valid      = 1'b1;
    ex_branch     = 1'b1;
    ex_pc         = pc;
    ex_funct3     = f3;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = pt;
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic t, input logic m, input logic il);
    expect_val({name, "_taken"}, K_TAKEN, 32'(t));
    expect_val({name, "_misp"}, K_MISP, 32'(m));
    expect_val({name, "_ill"}, K_ILL, 32'(il));
  endtask

  task automatic expect_perf(input string name, input int pb, input int pm);
    expect_val({name, "_pb"}, K_PB, 32'(pb));
    expect_val({name, "_pm"}, K_PM, 32'(pm));
  endtask

  // Monitor: outputs are combinational/registered and stable by the falling edge.
  always @(negedge clk) begin
    logic [31:0] act;
    while (q_kind.size() > 0) begin
      string n;
      int k;
      logic [31:0] v;
      n = q_name.pop_front();
      k = q_kind.pop_front();
      v = q_val.pop_front();
      case (k)
        K_PRED:  act = 32'(pred_taken);
        K_TAKEN: act = 32'(taken);
        K_MISP:  act = 32'(mispredict);
        K_ILL:   act = 32'(illegal_cond);
        K_PB:    act = perf_branches;
        default: act = perf_mispredicts;
      endcase
      checks++;
      if (act !== v) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", n, act, v);
      end
    end
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    reset = 1'b1;
    if_pc = '0;
    ex_pc = '0;
    ex_funct3 = '0;
    ex_rs1 = '0;
    ex_rs2 = '0;
    ex_pred_taken = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0 || pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct: pb=%0h pm=%0h pred=%0b", perf_branches, perf_mispredicts,
               pred_taken);
    end

    // Reset state: every entry weakly not-taken, perf counters cleared.
    expect_perf("rst", 0, 0);
    for (int i = 0; i < 64; i++) begin
      if_pc = 64'(i * 4);
      expect_val($sformatf("rst_pred_%0d", i), K_PRED, 32'd0);
      step();
    end

    // Condition sweep at ex_pc 0x80 with prediction not-taken.
    branch(64'h80, F3_BLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    expect_res("blt", 1'b1, 1'b1, 1'b0);
    step();
    branch(64'h80, F3_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    expect_res("bltu", 1'b0, 1'b0, 1'b0);
    step();
    branch(64'h80, F3_BGEU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    expect_res("bgeu", 1'b1, 1'b1, 1'b0);
    step();
    branch(64'h80, F3_BEQ, 64'd5, 64'd5, 1'b0);
    expect_res("beq", 1'b1, 1'b1, 1'b0);
    step();
    branch(64'h80, F3_BNE, 64'd5, 64'd5, 1'b0);
    expect_res("bne", 1'b0, 1'b0, 1'b0);
    step();
    branch(64'h80, F3_BGE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    expect_res("bge", 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_perf("sweep", 6, 3);
    step();

    // Training at 0x40: counter 1 -> 2 -> 3 -> 3 (sat) -> 2 -> 1.
    if_pc = 64'h40;
    for (int i = 0; i < 3; i++) begin
      branch(64'h40, F3_BEQ, 64'd7, 64'd7, 1'b0);
      expect_val($sformatf("train_t%0d_pred", i), K_PRED, (i == 0) ? 32'd0 : 32'd1);
      expect_res($sformatf("train_t%0d", i), 1'b1, 1'b1, 1'b0);
      step();
    end
    branch(64'h40, F3_BNE, 64'd7, 64'd7, 1'b1);
    expect_val("train_n0_pred", K_PRED, 32'd1);
    expect_res("train_n0", 1'b0, 1'b1, 1'b0);
    step();
    branch(64'h40, F3_BNE, 64'd7, 64'd7, 1'b0);
    expect_val("train_n1_pred", K_PRED, 32'd1);
    expect_res("train_n1", 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_val("train_end_pred", K_PRED, 32'd0);
    expect_perf("train", 11, 7);
    step();

    // Alias 0x140 onto idx 16 while IF reads 0x40: no same-cycle bypass.
    branch(64'h140, F3_BEQ, 64'd1, 64'd1, 1'b1);
    expect_val("alias_same_pred", K_PRED, 32'd0);
    expect_res("alias", 1'b1, 1'b0, 1'b0);
    step();
    idle();
    expect_val("alias_next_pred", K_PRED, 32'd1);
    step();

    // Illegal encodings must not decrement the counter (2) nor count.
    branch(64'h40, 3'b010, 64'd3, 64'd3, 1'b0);
    expect_res("ill010", 1'b0, 1'b0, 1'b1);
    step();
    branch(64'h40, 3'b011, 64'd1, 64'd2, 1'b1);
    expect_res("ill011", 1'b0, 1'b0, 1'b1);
    step();
    idle();
    expect_val("ill_pred", K_PRED, 32'd1);
    expect_perf("ill", 12, 7);
    step();

    // Bubbles: a not-taken update here would drop the counter to 1.
    branch(64'h40, F3_BNE, 64'd3, 64'd3, 1'b1);
    ex_valid = 1'b0;
    expect_res("bubble_v0", 1'b0, 1'b0, 1'b0);
    step();
    branch(64'h40, F3_BNE, 64'd3, 64'd3, 1'b1);
    ex_branch = 1'b0;
    expect_res("bubble_b0", 1'b0, 1'b0, 1'b0);
    step();
    branch(64'h40, 3'b010, 64'd3, 64'd3, 1'b1);
    ex_valid = 1'b0;
    expect_res("bubble_ill", 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_val("bubble_pred", K_PRED, 32'd1);
    expect_perf("bubble", 12, 7);
    step();

    // Mid-run reset with a taken branch presented: update discarded.
    reset = 1'b1;
    branch(64'h40, F3_BEQ, 64'd9, 64'd9, 1'b0);
    expect_res("rstcyc", 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    idle();
    expect_val("midrst_pred", K_PRED, 32'd0);
    expect_perf("midrst", 0, 0);
    step();
    // Counter is exactly 1: one taken update flips the prediction.
    branch(64'h40, F3_BEQ, 64'd9, 64'd9, 1'b0);
    expect_val("post_rst_pre", K_PRED, 32'd0);
    step();
    idle();
    expect_val("post_rst_pred", K_PRED, 32'd1);
    expect_perf("post_rst", 1, 1);
    step();

    done = 1'b1;
  end

endmodule
